// File: rtl/board_io_ctrl.sv
// Board I/O front-end: core reset sequencer, switch debouncers and PWM-dimmed LED drivers.
// Define BOARD_IO_EVT_EN to build the sticky switch-change event flags and irq_o.
module board_io_ctrl #(
    parameter int SW_NUM     = 16,
    parameter int LED_NUM    = 16,
    parameter int DEB_CYCLES = 1000,
    parameter int RST_HOLD   = 64,
    parameter int PWM_W      = 8
) (
    input  logic               clk_i,
    input  logic               arstn_i,
    input  logic               pll_locked_i,
    output logic               sys_rst_o,
    input  logic [SW_NUM-1:0]  sw_i,
    output logic [SW_NUM-1:0]  sw_o,
    input  logic [LED_NUM-1:0] led_i,
    input  logic [PWM_W-1:0]   led_bright_i,
    output logic [LED_NUM-1:0] led_o,
    input  logic [SW_NUM-1:0]  evt_clr_i,
    output logic [SW_NUM-1:0]  sw_evt_o,
    output logic               irq_o
);
    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    logic              lock_meta_q;
    logic              lock_s_q;
    logic [SW_NUM-1:0] sw_meta_q;
    logic [SW_NUM-1:0] sw_s_q;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            sw_meta_q   <= '0;
            sw_s_q      <= '0;
        end else begin
            lock_meta_q <= pll_locked_i;
            lock_s_q    <= lock_meta_q;
            sw_meta_q   <= sw_i;
            sw_s_q      <= sw_meta_q;
        end
    end

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } rst_state_e;

    rst_state_e        state_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              sys_rst_q;

    // sys_rst_q is loaded with the value belonging to the state being entered.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q    <= WAIT_LOCK;
            hold_cnt_q <= '0;
            sys_rst_q  <= 1'b1;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    hold_cnt_q <= '0;
                    sys_rst_q  <= 1'b1;
                    if (lock_s_q) state_q <= HOLD;
                end
                HOLD: begin
                    if (!lock_s_q) begin
                        state_q    <= WAIT_LOCK;
                        hold_cnt_q <= '0;
                        sys_rst_q  <= 1'b1;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_q    <= RUN;
                        hold_cnt_q <= '0;
                        sys_rst_q  <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                        sys_rst_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s_q) begin
                        state_q   <= WAIT_LOCK;
                        sys_rst_q <= 1'b1;
                    end else begin
                        sys_rst_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= WAIT_LOCK;
                    hold_cnt_q <= '0;
                    sys_rst_q  <= 1'b1;
                end
            endcase
        end
    end

    logic [SW_NUM-1:0] sw_q;
    logic [DEB_W-1:0]  deb_cnt_q [SW_NUM];

    // Debouncers follow the board reset only, so switch state survives core resets.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            sw_q <= '0;
            for (int i = 0; i < SW_NUM; i++) deb_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < SW_NUM; i++) begin
                if (sw_s_q[i] == sw_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DEB_LAST) begin
                    sw_q[i]      <= sw_s_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic [PWM_W-1:0]   pwm_cnt_q;
    logic [LED_NUM-1:0] led_q;
    logic               pwm_on;

    assign pwm_on = (pwm_cnt_q < led_bright_i) || (&led_bright_i);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            pwm_cnt_q <= '0;
            led_q     <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            led_q     <= sys_rst_q ? '0 : (led_i & {LED_NUM{pwm_on}});
        end
    end

`ifdef BOARD_IO_EVT_EN
    logic [SW_NUM-1:0] sw_prev_q;
    logic [SW_NUM-1:0] sw_evt_q;
    logic [SW_NUM-1:0] evt_d;
    logic              irq_q;

    // A toggle in the same cycle as a clear wins, so no change is ever lost.
    assign evt_d = (sw_evt_q & ~evt_clr_i) | (sw_q ^ sw_prev_q);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            sw_prev_q <= '0;
            sw_evt_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            sw_prev_q <= sw_q;
            sw_evt_q  <= evt_d;
            irq_q     <= |evt_d;
        end
    end

    assign sw_evt_o = sw_evt_q;
    assign irq_o    = irq_q;
`else
    logic unused_evt_clr;
    assign unused_evt_clr = ^evt_clr_i;
    assign sw_evt_o       = '0;
    assign irq_o          = 1'b0;
`endif

    assign sys_rst_o = sys_rst_q;
    assign sw_o      = sw_q;
    assign led_o     = led_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl: reset sequencing, debounce timing, PWM duty, events, async reset.
module tb_board_io_ctrl;
    localparam int SW_NUM  = 16;
    localparam int LED_NUM = 16;
    localparam int PWM_W   = 8;

`ifdef BOARD_IO_EVT_EN
    localparam bit EVT = 1'b1;
`else
    localparam bit EVT = 1'b0;
`endif

    logic               clk;
    logic               arstn;
    logic               pll_locked;
    logic               sys_rst;
    logic [SW_NUM-1:0]  sw_in;
    logic [SW_NUM-1:0]  sw_out;
    logic [LED_NUM-1:0] led_in;
    logic [PWM_W-1:0]   bright;
    logic [LED_NUM-1:0] led_out;
    logic [SW_NUM-1:0]  evt_clr;
    logic [SW_NUM-1:0]  sw_evt;
    logic               irq;

    int n_cmp = 0;
    int n_err = 0;

    board_io_ctrl #(
        .SW_NUM    (SW_NUM),
        .LED_NUM   (LED_NUM),
        .DEB_CYCLES(8),
        .RST_HOLD  (64),
        .PWM_W     (PWM_W)
    ) dut (
        .clk_i       (clk),
        .arstn_i     (arstn),
        .pll_locked_i(pll_locked),
        .sys_rst_o   (sys_rst),
        .sw_i        (sw_in),
        .sw_o        (sw_out),
        .led_i       (led_in),
        .led_bright_i(bright),
        .led_o       (led_out),
        .evt_clr_i   (evt_clr),
        .sw_evt_o    (sw_evt),
        .irq_o       (irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic count_led(input int cycles, input logic [LED_NUM-1:0] on_val,
                             output int n_on, output int n_bad);
        n_on  = 0;
        n_bad = 0;
        for (int i = 0; i < cycles; i++) begin
            tick(1);
            if (led_out === on_val) n_on++;
            else if (led_out !== '0) n_bad++;
        end
    endtask

    initial begin
        int cnt;
        int bad;
        int trans;
        logic prev7;

        arstn      = 1'b0;
        pll_locked = 1'b1;
        sw_in      = '0;
        led_in     = 16'hFFFF;
        bright     = 8'd255;
        evt_clr    = '0;
        tick(3);

        chk("reset_sys_rst", 32'(sys_rst), 32'd1);
        chk("reset_sw_o", 32'(sw_out), 32'd0);
        chk("reset_led_o", 32'(led_out), 32'd0);
        chk("reset_sw_evt", 32'(sw_evt), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);

        // reset release with lock already present: 2 sync + 1 + 64 cycles
        arstn = 1'b1;
        cnt   = 0;
        for (int i = 0; i < 66; i++) begin
            tick(1);
            if (sys_rst === 1'b1 && led_out === '0) cnt++;
        end
        chk("rst_hold_cycles", 32'(cnt), 32'd66);
        tick(1);
        chk("rst_release_c67", 32'(sys_rst), 32'd0);
        chk("led_at_release", 32'(led_out), 32'd0);
        tick(1);
        chk("led_after_release", 32'(led_out), 32'hFFFF);

        // PWM duty
        led_in = 16'hA5C3;
        tick(2);
        chk("led_pattern_full", 32'(led_out), 32'hA5C3);
        bright = 8'd64;
        tick(2);
        count_led(256, 16'hA5C3, cnt, bad);
        chk("pwm64_on", 32'(cnt), 32'd64);
        chk("pwm64_bad", 32'(bad), 32'd0);
        bright = 8'd0;
        tick(2);
        count_led(256, 16'hA5C3, cnt, bad);
        chk("pwm0_on", 32'(cnt + bad), 32'd0);
        bright = 8'd1;
        tick(2);
        count_led(256, 16'hA5C3, cnt, bad);
        chk("pwm1_on", 32'(cnt), 32'd1);
        bright = 8'd255;
        tick(2);
        count_led(256, 16'hA5C3, cnt, bad);
        chk("pwm255_on", 32'(cnt), 32'd256);
        led_in = 16'hFFFF;

        // debounce: held edge accepted 10 cycles later
        sw_in = 16'h0008;
        tick(9);
        chk("deb_hold_c9", 32'(sw_out), 32'h0000);
        tick(1);
        chk("deb_hold_c10", 32'(sw_out), 32'h0008);

        // 7-cycle pulse rejected
        sw_in = 16'h0028;
        bad   = 0;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            if (sw_out !== 16'h0008) bad++;
        end
        sw_in = 16'h0008;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (sw_out !== 16'h0008) bad++;
        end
        chk("deb_pulse7_reject", 32'(bad), 32'd0);

        // 8-cycle pulse is the shortest accepted
        sw_in = 16'h0048;
        tick(8);
        sw_in = 16'h0008;
        tick(1);
        chk("deb_pulse8_c9", 32'(sw_out), 32'h0008);
        tick(1);
        chk("deb_pulse8_c10", 32'(sw_out), 32'h0048);
        tick(8);
        chk("deb_pulse8_fall", 32'(sw_out), 32'h0008);

        // bounce 1,0,1 every 3 cycles then stable: one transition
        trans = 0;
        bad   = 0;
        prev7 = sw_out[7];
        for (int i = 0; i < 36; i++) begin
            if (i < 3) sw_in = 16'h0088;
            else if (i < 6) sw_in = 16'h0008;
            else sw_in = 16'h0088;
            tick(1);
            if (sw_out[7] !== prev7) trans++;
            prev7 = sw_out[7];
            if ((sw_out & 16'hFF7F) !== 16'h0008) bad++;
        end
        chk("deb_bounce_trans", 32'(trans), 32'd1);
        chk("deb_bounce_other", 32'(bad), 32'd0);
        chk("deb_bounce_final", 32'(sw_out), 32'h0088);

        // events: clear, set on toggle, clear, set wins over clear
        evt_clr = 16'hFFFF;
        tick(1);
        evt_clr = '0;
        tick(1);
        chk("evt_cleared_all", 32'(sw_evt), 32'd0);
        chk("irq_cleared_all", 32'(irq), 32'd0);
        sw_in = 16'h0089;
        tick(10);
        chk("evt_sw0_accept", 32'(sw_out), 32'h0089);
        chk("evt_before_set", 32'(sw_evt), 32'd0);
        tick(1);
        chk("evt_set", 32'(sw_evt), EVT ? 32'h0001 : 32'h0);
        chk("irq_set", 32'(irq), EVT ? 32'd1 : 32'd0);
        evt_clr = 16'h0001;
        tick(1);
        evt_clr = '0;
        chk("evt_clear", 32'(sw_evt), 32'd0);
        chk("irq_clear", 32'(irq), 32'd0);
        sw_in = 16'h0088;
        tick(10);
        evt_clr = 16'h0001;
        tick(1);
        evt_clr = '0;
        chk("evt_set_wins", 32'(sw_evt), EVT ? 32'h0001 : 32'h0);
        evt_clr = 16'hFFFF;
        tick(1);
        evt_clr = '0;

        // PLL lock drop for one cycle
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(2);
        chk("lock_drop_rst", 32'(sys_rst), 32'd1);
        tick(2);
        chk("lock_drop_led", 32'(led_out), 32'd0);
        chk("lock_drop_sw_kept", 32'(sw_out), 32'h0088);
        cnt = 0;
        for (int i = 0; i < 62; i++) begin
            tick(1);
            if (sys_rst === 1'b1) cnt++;
        end
        chk("relock_hold", 32'(cnt), 32'd62);
        tick(1);
        chk("relock_release", 32'(sys_rst), 32'd0);
        tick(2);
        chk("led_before_arst", 32'(led_out), 32'hFFFF);

        // async reset mid-debounce and mid-PWM
        sw_in = 16'h0000;
        tick(4);
        #3;
        arstn = 1'b0;
        #1;
        chk("arst_sys_rst", 32'(sys_rst), 32'd1);
        chk("arst_sw_o", 32'(sw_out), 32'd0);
        chk("arst_led_o", 32'(led_out), 32'd0);
        chk("arst_evt", 32'(sw_evt), 32'd0);
        chk("arst_irq", 32'(irq), 32'd0);
        tick(1);
        arstn = 1'b1;
        bad   = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (sw_out !== '0 || sw_evt !== '0 || irq !== 1'b0 || led_out !== '0) bad++;
        end
        chk("arst_no_stale", 32'(bad), 32'd0);
        chk("arst_rehold", 32'(sys_rst), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
